// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DBIT         = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, pulses bit_end on the last clk of each bit
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = !clear && (cnt_q == LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary; clear parks it at 0
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-draining UART transmitter, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DBIT         = UART_DBIT,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] rd_data,
  output logic            read,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int            BW        = $clog2(DBIT);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t       state_q;
  logic [DBIT-1:0] shreg_q;
  logic [BW-1:0]   bit_cnt_q;
  logic            stop_cnt_q;
  logic            tx_q;
  logic            busy_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic bit_end;
  logic baud_clear;

  // Baud counter idles at 0 so the start bit gets a full period after the pop
  assign baud_clear = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  assign read         = (state_q == IDLE) && !empty && !reset;
  assign tx_done_tick = (state_q == STOP) && bit_end && (stop_cnt_q == LAST_STOP);
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

  // Frame sequencer: tx_q is loaded with the level of the bit being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shreg_q    <= rd_data;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^rd_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              tx_q      <= shreg_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == LAST_STOP) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DB + P + SB;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       read;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DBIT        (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .rd_data     (rd_data),
    .read        (read),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  bit         rst_req  = 1'b1;
  bit         scramble = 1'b0;

  bit         m_active = 1'b0;
  int         m_pop    = 0;
  logic [7:0] m_byte   = 8'h00;
  int         n_reads  = 0;
  int         last_read = -1;
  int         pop_cycles[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_in_frame(input int c);
    return m_active && (c >= m_pop + 1) && (c <= m_pop + FRAME);
  endfunction

  // Line level at frame offset: start(0), data LSB first, optional even parity, stop(1)
  function automatic logic m_line(input int c);
    int idx;
    idx = (c - m_pop - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return m_byte[idx-1];
    if (P == 1 && idx == DB + 1) return ^m_byte;
    return 1'b1;
  endfunction

  task automatic step();
    bit exp_in;
    bit exp_read;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_req;
    empty = (fifo_q.size() == 0);
    if (!empty && !m_in_frame(cyc)) rd_data = fifo_q[0];
    else if (scramble) rd_data = 8'($urandom);
    @(negedge clk);
    exp_in   = m_in_frame(cyc);
    exp_read = !exp_in && !empty && !reset;
    check("tx", 32'(tx), exp_in ? 32'(m_line(cyc)) : 32'd1);
    check("tx_busy", 32'(tx_busy), 32'(exp_in));
    check("read", 32'(read), 32'(exp_read));
    if (!reset) check("tx_done_tick", 32'(tx_done_tick), 32'(exp_in && (cyc == m_pop + FRAME)));
    if (reset) m_active = 1'b0;
    else if (exp_read) begin
      m_active = 1'b1;
      m_pop    = cyc;
      m_byte   = rd_data;
    end
    if (read === 1'b1) begin
      n_reads++;
      last_read = cyc;
      pop_cycles.push_back(cyc);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_reads(input int target, input int bound);
    for (int i = 0; i < bound && n_reads < target; i++) step();
    check("read_timeout", 32'(n_reads >= target), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() == 0 && !m_in_frame(cyc + 1) && !m_in_frame(cyc)) break;
      step();
    end
    check("drain", 32'(fifo_q.size()), 32'd0);
    run(3);
  endtask

  initial begin
    int base;
    int p;
    int nb;

    // Reset held, then idle with an empty FIFO
    rst_req = 1'b1;
    run(3);
    rst_req = 1'b0;
    run(100);
    check("idle_reads", 32'(n_reads), 32'd0);
    check("idle_tx", 32'(tx), 32'd1);

    // Single byte 0x4B
    base = n_reads;
    fifo_q.push_back(8'd75);
    wait_reads(base + 1, 20);
    run(FRAME + 5);
    check("single_read", 32'(n_reads - base), 32'd1);

    // Back-to-back 0x4B, 0x20
    base = n_reads;
    fifo_q.push_back(8'd75);
    fifo_q.push_back(8'd32);
    wait_reads(base + 2, 3 * FRAME);
    check("pop_pitch", 32'(pop_cycles[pop_cycles.size()-1] - pop_cycles[pop_cycles.size()-2]), 32'(FRAME + 1));
    run(FRAME + 20);
    check("no_third_read", 32'(n_reads - base), 32'd2);

    // Reset during data bit 3, FIFO still non-empty
    base = n_reads;
    fifo_q.push_back(8'd75);
    fifo_q.push_back(8'hA5);
    wait_reads(base + 1, 20);
    p = last_read;
    while (cyc < p + 17) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    check("read_after_reset", 32'(last_read), 32'(p + 19));
    drain();
    check("reset_reads", 32'(n_reads - base), 32'd2);

    // rd_data churning every cycle outside the pop
    scramble = 1'b1;
    base = n_reads;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'd7);
    drain();
    check("scramble_reads", 32'(n_reads - base), 32'd7);

    // Random pushes, gaps and occasional resets
    for (int i = 0; i < 24; i++) begin
      nb = $urandom_range(0, 2);
      for (int j = 0; j < nb; j++) fifo_q.push_back(8'($urandom));
      scramble = ($urandom_range(0, 1) == 1);
      run($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) begin
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
      end
    end
    drain();
    check("final_idle_tx", 32'(tx), 32'd1);
    check("final_idle_busy", 32'(tx_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the thermometer's byte FIFO onto the UART line. It is the reader on the FIFO's read port. When the FIFO is non-empty and the transmitter is idle, it pops one byte, then shifts it out LSB-first as an 8N1 frame (optionally 8E1). The block sits between `fifo_buffer` (read side) and the board's TX pin.

## Interface
- `CLKS_PER_BIT`, 868 — clk cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `DBIT`, 8 — data bits per frame; must equal the FIFO word width.
- `STOP_BITS`, 1 — number of stop bits, 1 or 2.
- `clk` in 1 — single system clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `empty` in 1 — FIFO empty flag.
- `rd_data` in DBIT — FIFO head word, valid whenever `empty`=0 (first-word-fall-through).
- `read` out 1 — FIFO pop strobe, one-cycle pulse.
- `tx` out 1 — serial line, idle high.
- `tx_busy` out 1 — high from the cycle after the pop until the frame ends.
- `tx_done_tick` out 1 — one-cycle pulse on the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx`=1.
  - If `empty`=0: assert `read` for this cycle only, capture `rd_data` into the shift register, clear the bit and baud counters, go to START.
  - If `empty`=1: hold IDLE with `read`=0.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx`=shreg[0] for CLKS_PER_BIT cycles per bit; shift right at the end of each bit.
  - After DBIT bits, go to PARITY, or to STOP when parity is compiled out.
- PARITY: `tx`=XOR of the captured byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the final cycle, pulse `tx_done_tick` and go to IDLE.
- `read` is never asserted while `empty`=1 or outside IDLE. Changes on `empty` during a frame are ignored.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; it counts 0..CLKS_PER_BIT−1 and wraps to 0 at each bit boundary.
  - Bit counter: $clog2(DBIT) bits.
  - Stop counter: 1 bit.
- Reset mid-frame:
  - The frame is aborted; the next cycle shows `tx`=1, `tx_busy`=0, state IDLE.
  - The already-popped byte is lost. There is no retransmit.

## Timing
- Reset values: `tx`=1, `read`=0, `tx_busy`=0, `tx_done_tick`=0, state IDLE, all counters 0.
- `tx` and `tx_busy` are registered outputs. `read` is a combinational decode of (state==IDLE && !empty && !reset).
- Pop cycle N: `tx` falls at N+1.
- Frame length: (1 + DBIT + P + STOP_BITS)×CLKS_PER_BIT cycles, with P=1 if parity is compiled in, else 0.
- `tx_done_tick` fires in the last frame cycle. The next cycle is IDLE.
- Back-to-back bytes: the pop-to-pop pitch is frame length + 1 cycle. The line shows exactly one extra clk cycle of idle-high between frames.
- Data is sampled from `rd_data` only in the pop cycle. Later changes on `rd_data` have no effect.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present; each frame carries an even-parity bit between the data and stop bits; frame = 8E1.
- `UART_TX_PARITY_EN` undefined: PARITY state and parity logic are absent; frame = 8N1.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Default constants: `UART_CLKS_PER_BIT`=868, `UART_DBIT`=8.
- Sub-module `uart_baud_counter`:
  - Clear input, `bit_end` output pulse.
  - Counts CLKS_PER_BIT cycles; reused by the future receiver.
- The FSM, shift register and bit counter stay in `uart_tx`.

## Test plan
All tests use CLKS_PER_BIT=4, STOP_BITS=1, and a 10 ns clk.
- Reset held 3 cycles, then `empty`=1 for 100 cycles -> `tx`=1, `read`=0, `tx_busy`=0 throughout.
- FIFO holds 75 (0x4B) -> single `read` pulse; `tx` sequence per 4 cycles: 0, 1,1,0,1,0,0,1,0, 1; `tx_done_tick` at pop+40; `tx_busy` high for 40 cycles.
- FIFO holds 75 then 32 -> second `read` exactly 41 cycles after the first; second data bits 0,0,0,0,0,1,0,0; `empty` rises after the second pop and no third `read` occurs.
- `reset` asserted during data bit 3 of 75 -> next cycle `tx`=1, `tx_busy`=0; with `empty`=0 after release, a fresh `read` occurs one cycle after `reset` falls.
- `rd_data` toggled every cycle during the frame -> transmitted bits match the value captured in the pop cycle only.
- With `UART_TX_PARITY_EN`: byte 75 -> parity bit 0; byte 7 -> parity bit 1; frame 44 cycles; pop pitch 45 cycles.
